// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared FIFO types and the parity helper used at both FIFO ports
package fifo_pkg;

  // Widest FIFO word the parity helper accepts; narrower words are zero-extended
  // by the caller, which leaves the XOR reduction unchanged.
  localparam int MAX_WORD_W = 129;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_t;

  function automatic logic parity_ok(input logic [MAX_WORD_W-1:0] word,
                                     input logic                  even_odd,
                                     input logic                  parity_bit);
    return !(parity_bit && ((^word) != even_odd));
  endfunction

endpackage

// File: rtl/pop_skid_buffer.sv
// rtl/pop_skid_buffer.sv - 2-entry in-order skid buffer with registered valid and occupancy
module pop_skid_buffer
  import fifo_pkg::*;
#(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready,
  output logic [1:0]   occupancy
);

  occ_t         occ_q;
  logic [W-1:0] head_q;
  logic [W-1:0] tail_q;
  logic         out_fire;

  assign out_fire  = out_valid & out_ready;
  assign out_data  = head_q;
  assign occupancy = occ_q;

  // head_q always drives the output; tail_q only holds the second word while stalled.
  // The writer never pushes in OCC_TWO, so that state only waits for a drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q     <= OCC_EMPTY;
      head_q    <= '0;
      tail_q    <= '0;
      out_valid <= 1'b0;
    end else begin
      unique case (occ_q)
        OCC_EMPTY: begin
          if (in_valid) begin
            head_q    <= in_data;
            occ_q     <= OCC_ONE;
            out_valid <= 1'b1;
          end
        end
        OCC_ONE: begin
          if (in_valid && out_fire) begin
            head_q <= in_data;
          end else if (in_valid) begin
            tail_q <= in_data;
            occ_q  <= OCC_TWO;
          end else if (out_fire) begin
            occ_q     <= OCC_EMPTY;
            out_valid <= 1'b0;
          end
        end
        OCC_TWO: begin
          if (out_fire) begin
            head_q <= tail_q;
            occ_q  <= OCC_ONE;
          end
        end
        default: begin
          occ_q     <= OCC_EMPTY;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/pop_parity_checker.sv
// rtl/pop_parity_checker.sv - FIFO pop-side parity check, error counting and skid-buffered output
module pop_parity_checker
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter bit EVEN_ODD   = 1'b0,
  parameter bit PARITY_BIT = 1'b1,
  parameter bit DROP_BAD   = 1'b0,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH:0]   pop_data_i,
  input  logic                  pop_valid_i,
  output logic                  pop_grant_o,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic                  out_perr_o,
  input  logic                  clr_err_i,
  output logic [ERR_CNT_W-1:0]  err_count_o,
  output logic                  err_sticky_o
);

  logic                ready_q;
  logic                pop_fire;
  logic                word_err;
  logic                buf_wr;
  logic [1:0]          occ;
  logic [DATA_WIDTH:0] buf_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ready_q <= 1'b0;
    else        ready_q <= 1'b1;
  end

  // Grant depends only on registered state so downstream ready never reaches the FIFO.
  assign pop_grant_o = ready_q & (occ != OCC_TWO);
  assign pop_fire    = pop_valid_i & pop_grant_o;
  assign word_err    = ~parity_ok(MAX_WORD_W'(pop_data_i), EVEN_ODD, PARITY_BIT);
  assign buf_wr      = pop_fire & ~(DROP_BAD & word_err);

  pop_skid_buffer #(
    .W (DATA_WIDTH + 1)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (buf_wr),
    .in_data   ({word_err, pop_data_i[DATA_WIDTH-1:0]}),
    .out_valid (out_valid_o),
    .out_data  (buf_out),
    .out_ready (out_ready_i),
    .occupancy (occ)
  );

  assign out_data_o = buf_out[DATA_WIDTH-1:0];
  assign out_perr_o = buf_out[DATA_WIDTH];

  // A bad word arriving with a clear request counts as the first error after the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count_o  <= '0;
      err_sticky_o <= 1'b0;
    end else if (pop_fire && word_err) begin
      err_sticky_o <= 1'b1;
      if (clr_err_i)               err_count_o <= ERR_CNT_W'(1);
      else if (err_count_o != '1) err_count_o <= err_count_o + 1'b1;
    end else if (clr_err_i) begin
      err_count_o  <= '0;
      err_sticky_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pop_parity_checker.sv
// tb/tb_pop_parity_checker.sv - self-checking bench for pop_parity_checker
module tb_pop_parity_checker;

  typedef struct {
    logic [31:0] payload;
    logic        par;
    logic        exp_perr;
  } vec_t;

  typedef struct packed {
    logic        perr;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [32:0] pop_data;
  logic        pop_valid;
  logic        pop_grant;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_perr;
  logic        clr_err;
  logic [7:0]  err_count;
  logic        err_sticky;

  logic [32:0] p2_data;
  logic        p2_valid;
  logic        g2;
  logic [31:0] o2_data;
  logic        o2_valid;
  logic        o2_ready;
  logic        o2_perr;
  logic        clr2;
  logic [3:0]  cnt2;
  logic        st2;

  int   total = 0;
  int   bad   = 0;
  exp_t q[$];
  logic cur_exp;
  logic rdy_m;
  vec_t tbl[7];
  int   nbad;

  always #5 clk = ~clk;

  pop_parity_checker dut (
    .clk (clk), .rst_n (rst_n),
    .pop_data_i (pop_data), .pop_valid_i (pop_valid), .pop_grant_o (pop_grant),
    .out_data_o (out_data), .out_valid_o (out_valid), .out_ready_i (out_ready),
    .out_perr_o (out_perr), .clr_err_i (clr_err),
    .err_count_o (err_count), .err_sticky_o (err_sticky)
  );

  pop_parity_checker #(.DROP_BAD(1'b1), .ERR_CNT_W(4)) dut_drop (
    .clk (clk), .rst_n (rst_n),
    .pop_data_i (p2_data), .pop_valid_i (p2_valid), .pop_grant_o (g2),
    .out_data_o (o2_data), .out_valid_o (o2_valid), .out_ready_i (o2_ready),
    .out_perr_o (o2_perr), .clr_err_i (clr2),
    .err_count_o (cnt2), .err_sticky_o (st2)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [32:0] enc(input logic [31:0] d, input logic flip);
    return {(^d) ^ flip, d};
  endfunction

  // grant is expected one edge after reset release
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdy_m <= 1'b0;
    else        rdy_m <= 1'b1;
  end

  // Scoreboard: queue holds what the output stage should contain after the last edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      chk("rst_valid", 64'(out_valid), 64'(0));
      chk("rst_grant", 64'(pop_grant), 64'(0));
    end else begin
      chk("grant", 64'(pop_grant), 64'(rdy_m && (q.size() < 2)));
      chk("valid", 64'(out_valid), 64'(q.size() != 0));
      if (out_valid && q.size() != 0) begin
        chk("data", 64'(out_data), 64'(q[0].data));
        chk("perr", 64'(out_perr), 64'(q[0].perr));
      end
      if (out_valid && out_ready && q.size() != 0) void'(q.pop_front());
      if (pop_valid && pop_grant) q.push_back({cur_exp, pop_data[31:0]});
    end
  end

  task automatic send(input logic [32:0] w, input logic e);
    logic ok;
    cur_exp   = e;
    pop_data  = w;
    pop_valid = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      ok = pop_grant;
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL send_timeout: got no grant expected grant for %0h", w);
    end
    @(posedge clk);
    #1;
    pop_valid = 1'b0;
  endtask

  task automatic drain();
    logic done;
    done = 1'b0;
    for (int n = 0; n < 50 && !done; n++) begin
      @(posedge clk);
      #1;
      done = (q.size() == 0);
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got %0d queued expected 0", q.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; pop_valid = 1'b1; pop_data = enc(32'h5, 1'b0); out_ready = 1'b1;
    clr_err = 1'b0; cur_exp = 1'b0;
    p2_valid = 1'b0; p2_data = '0; o2_ready = 1'b1; clr2 = 1'b0;

    // reset with a word offered
    #3;
    chk("rst_grant0", 64'(pop_grant), 64'(0));
    chk("rst_valid0", 64'(out_valid), 64'(0));
    chk("rst_data0", 64'(out_data), 64'(0));
    chk("rst_perr0", 64'(out_perr), 64'(0));
    chk("rst_count0", 64'(err_count), 64'(0));
    chk("rst_sticky0", 64'(err_sticky), 64'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("grant_after_release", 64'(pop_grant), 64'(1));
    chk("no_pop_in_reset", 64'(out_valid), 64'(0));
    pop_valid = 1'b0;

    // stream of good words
    for (int i = 1; i <= 30; i++) send(enc(32'(2 * i), 1'b0), 1'b0);
    drain();
    chk("stream_count", 64'(err_count), 64'(0));
    chk("stream_sticky", 64'(err_sticky), 64'(0));

    // table of parity vectors
    tbl[0] = '{32'h0000_0003, 1'b1, 1'b1};
    tbl[1] = '{32'h0000_0003, 1'b0, 1'b0};
    tbl[2] = '{32'h0000_0001, 1'b1, 1'b0};
    tbl[3] = '{32'h0000_0001, 1'b0, 1'b1};
    tbl[4] = '{32'hFFFF_FFFF, 1'b0, 1'b0};
    tbl[5] = '{32'h8000_0000, 1'b0, 1'b1};
    tbl[6] = '{32'hA5A5_A5A5, 1'b0, 1'b0};
    nbad = 0;
    for (int i = 0; i < 7; i++) begin
      send({tbl[i].par, tbl[i].payload}, tbl[i].exp_perr);
      nbad += int'(tbl[i].exp_perr);
    end
    drain();
    chk("tbl_count", 64'(err_count), 64'(nbad));
    chk("tbl_sticky", 64'(err_sticky), 64'(1));

    // backpressure: two captured, third waits
    out_ready = 1'b0;
    send(enc(32'h111, 1'b0), 1'b0);
    send(enc(32'h222, 1'b0), 1'b0);
    chk("bp_grant_full", 64'(pop_grant), 64'(0));
    cur_exp = 1'b0; pop_data = enc(32'h333, 1'b0); pop_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("bp_held_data", 64'(out_data), 64'(32'h111));
    chk("bp_grant_stall", 64'(pop_grant), 64'(0));
    out_ready = 1'b1;
    send(enc(32'h333, 1'b0), 1'b0);
    drain();

    // clear coinciding with a bad pop, then clear alone
    clr_err = 1'b1;
    send(enc(32'h3, 1'b1), 1'b1);
    clr_err = 1'b0;
    chk("clr_bad_count", 64'(err_count), 64'(1));
    chk("clr_bad_sticky", 64'(err_sticky), 64'(1));
    drain();
    clr_err = 1'b1;
    @(posedge clk); #1;
    clr_err = 1'b0;
    chk("clr_count", 64'(err_count), 64'(0));
    chk("clr_sticky", 64'(err_sticky), 64'(0));

    // drop-bad instance: 17 bad words saturate a 4-bit counter, none forwarded
    for (int i = 0; i < 17; i++) begin
      p2_data = enc(32'(16 + i), 1'b1);
      p2_valid = 1'b1;
      @(negedge clk);
      chk("drop_grant", 64'(g2), 64'(1));
      chk("drop_no_out", 64'(o2_valid), 64'(0));
      @(posedge clk); #1;
    end
    p2_valid = 1'b0;
    chk("sat_count", 64'(cnt2), 64'(15));
    chk("sat_sticky", 64'(st2), 64'(1));
    chk("drop_empty", 64'(o2_valid), 64'(0));
    p2_data = enc(32'hBEEF, 1'b0); p2_valid = 1'b1;
    @(posedge clk); #1;
    p2_valid = 1'b0;
    chk("drop_good_valid", 64'(o2_valid), 64'(1));
    chk("drop_good_data", 64'(o2_data), 64'(32'hBEEF));
    chk("drop_good_perr", 64'(o2_perr), 64'(0));

    // reset while two words are buffered
    out_ready = 1'b0;
    send(enc(32'hAAA, 1'b0), 1'b0);
    send(enc(32'hBBB, 1'b0), 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_valid", 64'(out_valid), 64'(0));
    chk("mr_grant", 64'(pop_grant), 64'(0));
    chk("mr_data", 64'(out_data), 64'(0));
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("mr_no_stale", 64'(out_valid), 64'(0));
    send(enc(32'hCAFE, 1'b0), 1'b0);
    drain();
    chk("q_empty", 64'(q.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
